// File: rtl/symbol_lock_aligner.sv
// Word alignment and symbol-lock FSM (HUNT/ACQ/LOCKED) behind the comma detector.
// Optional SYMBOL_ERR_CNT_EN adds the Err_Total lifetime error counter output.
module symbol_lock_aligner #(
  parameter int LOCK_COMMAS = 3,
  parameter int ERR_LIMIT   = 4,
  parameter int GOOD_RESET  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] Data_Collected,
  input  logic       Comma_Pulse,
  output logic [9:0] Symbol_Out,
  output logic       Symbol_Valid,
  output logic       Symbol_Lock,
`ifdef SYMBOL_ERR_CNT_EN
  output logic [15:0] Err_Total,
`endif
  output logic       Symbol_Err
);

  localparam logic [3:0] LOCK_C   = 4'(LOCK_COMMAS);
  localparam logic [3:0] ERR_C    = 4'(ERR_LIMIT);
  localparam logic [7:0] GOOD_C   = 8'(GOOD_RESET);
  localparam logic [3:0] PH_LAST  = 4'd9;

  typedef enum logic [1:0] {HUNT, ACQ, LOCKED} state_t;

  state_t     state, state_nx;
  logic [3:0] ph, ph_nx;
  logic [3:0] comma_cnt, comma_cnt_nx;
  logic [3:0] err_cnt, err_cnt_nx;
  logic [7:0] good_run, good_run_nx;
  logic       sticky, sticky_nx;
  logic       cap_p0, err_p0;
  logic       boundary, pop_bad;
  logic [3:0] err_inc, comma_inc;
  logic [7:0] good_inc;

  function automatic logic [3:0] popcount10(input logic [9:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 10; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

`ifdef SYMBOL_ERR_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  assign boundary  = (state != HUNT) && (ph == 4'd0);
  assign pop_bad   = (popcount10(Data_Collected) < 4'd4) || (popcount10(Data_Collected) > 4'd6);
  assign err_inc   = sat_inc4(err_cnt);
  assign comma_inc = sat_inc4(comma_cnt);
  assign good_inc  = good_run + 8'd1;

  always_comb begin
    state_nx     = state;
    ph_nx        = (ph == PH_LAST) ? 4'd0 : ph + 4'd1;
    comma_cnt_nx = comma_cnt;
    err_cnt_nx   = err_cnt;
    good_run_nx  = good_run;
    sticky_nx    = sticky;
    cap_p0       = 1'b0;
    err_p0       = 1'b0;
    case (state)
      HUNT: begin
        ph_nx = 4'd0;
        if (Comma_Pulse) begin
          cap_p0       = 1'b1;
          ph_nx        = 4'd1;
          comma_cnt_nx = 4'd1;
          state_nx     = (LOCK_C == 4'd1) ? LOCKED : ACQ;
        end
      end
      ACQ: begin
        if (boundary) begin
          cap_p0 = 1'b1;
          if (Comma_Pulse) begin
            comma_cnt_nx = comma_inc;
            if (comma_inc >= LOCK_C) state_nx = LOCKED;
          end
        end else if (Comma_Pulse) begin
          // Off-phase comma during acquisition restarts the symbol grid here
          cap_p0       = 1'b1;
          ph_nx        = 4'd1;
          comma_cnt_nx = 4'd1;
        end
      end
      LOCKED: begin
        if (boundary) begin
          cap_p0    = 1'b1;
          sticky_nx = 1'b0;
          if (pop_bad || sticky) begin
            err_p0      = 1'b1;
            good_run_nx = 8'd0;
            err_cnt_nx  = err_inc;
            if (err_inc >= ERR_C) begin
              state_nx     = HUNT;
              ph_nx        = 4'd0;
              comma_cnt_nx = 4'd0;
              err_cnt_nx   = 4'd0;
            end
          end else if (good_inc == GOOD_C) begin
            good_run_nx = 8'd0;
            err_cnt_nx  = (err_cnt == 4'd0) ? 4'd0 : err_cnt - 4'd1;
          end else begin
            good_run_nx = good_inc;
          end
        end else if (Comma_Pulse) begin
          // Misphase comma is only reported with the next boundary symbol
          sticky_nx = 1'b1;
        end
      end
      default: state_nx = HUNT;
    endcase
  end

  // Stage p0 -> output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= HUNT;
      ph           <= 4'd0;
      comma_cnt    <= 4'd0;
      err_cnt      <= 4'd0;
      good_run     <= 8'd0;
      sticky       <= 1'b0;
      Symbol_Out   <= 10'd0;
      Symbol_Valid <= 1'b0;
      Symbol_Err   <= 1'b0;
`ifdef SYMBOL_ERR_CNT_EN
      Err_Total    <= 16'd0;
`endif
    end else begin
      state        <= state_nx;
      ph           <= ph_nx;
      comma_cnt    <= comma_cnt_nx;
      err_cnt      <= err_cnt_nx;
      good_run     <= good_run_nx;
      sticky       <= sticky_nx;
      Symbol_Valid <= cap_p0;
      Symbol_Err   <= err_p0;
      if (cap_p0) Symbol_Out <= Data_Collected;
`ifdef SYMBOL_ERR_CNT_EN
      if (err_p0) Err_Total <= sat_inc16(Err_Total);
`endif
    end
  end

  assign Symbol_Lock = (state == LOCKED);

endmodule
